// File: rtl/pll_phase_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pll_phase_ctrl : PLL power-down/relock sequencer and phase-shift serialiser |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pll_phase_ctrl #(
    parameter int PD_HOLD    = 16,
    parameter int LOCK_WAIT  = 256,
    parameter int ROTATE_GAP = 4,
    parameter int STEP_W     = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PLL_LOCK,
    input  logic              RESTART,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [2:0]        REQ_SEL,
    input  logic              REQ_DIR,
    input  logic [STEP_W-1:0] REQ_STEPS,
    output logic              PLL_POWERDOWN_N,
    output logic              PHASE_OUT0_SEL,
    output logic              PHASE_OUT2_SEL,
    output logic              PHASE_OUT3_SEL,
    output logic              PHASE_DIRECTION,
    output logic              PHASE_ROTATE,
    output logic              LOAD_PHASE_N,
    output logic              PLL_READY,
    output logic              DONE,
    output logic              ERR
);

    localparam int CNT_MAX = (PD_HOLD > LOCK_WAIT)
                           ? ((PD_HOLD > ROTATE_GAP) ? PD_HOLD : ROTATE_GAP)
                           : ((LOCK_WAIT > ROTATE_GAP) ? LOCK_WAIT : ROTATE_GAP);
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  PD_LAST   = CNT_W'(PD_HOLD - 1);
    localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_WAIT - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(ROTATE_GAP - 2);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    typedef enum logic [3:0] {
        S_PD        = 4'd0,
        S_WAIT_LOCK = 4'd1,
        S_STABLE    = 4'd2,
        S_IDLE      = 4'd3,
        S_SETUP     = 4'd4,
        S_ROT       = 4'd5,
        S_GAP       = 4'd6,
        S_LOAD      = 4'd7,
        S_FINISH    = 4'd8
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        lock_sync;
    logic              lock;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [STEP_W-1:0] rem, rem_nxt;
    logic [2:0]        sel_q, sel_nxt;
    logic              dir_q, dir_nxt;
    logic              err_q, err_nxt;
    logic              shifting;

    assign lock = lock_sync[1];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_PD;
            lock_sync <= 2'b00;
            cnt       <= '0;
            rem       <= '0;
            sel_q     <= 3'b000;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            lock_sync <= {lock_sync[0], PLL_LOCK};
            cnt       <= cnt_nxt;
            rem       <= rem_nxt;
            sel_q     <= sel_nxt;
            dir_q     <= dir_nxt;
            err_q     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rem_nxt   = rem;
        sel_nxt   = sel_q;
        dir_nxt   = dir_q;
        err_nxt   = 1'b0;
        case (state)
            S_PD: begin
                if (cnt == PD_LAST) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_WAIT_LOCK: begin
                if (lock) begin
                    state_nxt = S_STABLE;
                    cnt_nxt   = '0;
                end
            end
            S_STABLE: begin
                if (!lock) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_IDLE: begin
                // Restart beats everything; lock loss beats a new request.
                if (RESTART) begin
                    state_nxt = S_PD;
                    cnt_nxt   = '0;
                end else if (!lock) begin
                    state_nxt = S_WAIT_LOCK;
                end else if (REQ_VALID) begin
                    if (REQ_STEPS == '0 || REQ_SEL == 3'b000) begin
                        state_nxt = S_FINISH;
                    end else begin
                        sel_nxt   = REQ_SEL;
                        dir_nxt   = REQ_DIR;
                        rem_nxt   = REQ_STEPS;
                        state_nxt = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (!lock) begin
                    state_nxt = S_WAIT_LOCK;
                    err_nxt   = 1'b1;
                end else begin
                    state_nxt = S_ROT;
                end
            end
            S_ROT: begin
                if (!lock) begin
                    state_nxt = S_WAIT_LOCK;
                    err_nxt   = 1'b1;
                end else begin
                    rem_nxt   = rem - STEP_ONE;
                    cnt_nxt   = '0;
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (!lock) begin
                    state_nxt = S_WAIT_LOCK;
                    err_nxt   = 1'b1;
                end else if (cnt == GAP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = (rem != '0) ? S_ROT : S_LOAD;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_LOAD: begin
                if (!lock) begin
                    state_nxt = S_WAIT_LOCK;
                    err_nxt   = 1'b1;
                end else begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                state_nxt = lock ? S_IDLE : S_WAIT_LOCK;
            end
            default: begin
                state_nxt = S_PD;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Phase pins are decoded from state so an async reset clears them at once.
    assign shifting        = (state == S_SETUP) || (state == S_ROT) ||
                             (state == S_GAP)   || (state == S_LOAD);
    assign PLL_POWERDOWN_N = (state != S_PD);
    assign PHASE_OUT0_SEL  = shifting & sel_q[0];
    assign PHASE_OUT2_SEL  = shifting & sel_q[1];
    assign PHASE_OUT3_SEL  = shifting & sel_q[2];
    assign PHASE_DIRECTION = shifting & dir_q;
    assign PHASE_ROTATE    = (state == S_ROT);
    assign LOAD_PHASE_N    = (state != S_LOAD);
    assign PLL_READY       = (state == S_IDLE) || shifting || (state == S_FINISH);
    assign REQ_READY       = (state == S_IDLE) && lock && !RESTART;
    assign DONE            = (state == S_FINISH);
    assign ERR             = err_q;

endmodule
`default_nettype wire
